// File: rtl/cr_pipe_pkg.sv
// Shared types and constant helpers for the pipelined round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cr_pipe_pkg;

    // Largest requester count the arbiter supports.
    localparam int CR_MAX_REQS = 16;

    // Ceiling log2 used at elaboration time.
    function automatic int cr_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Priority pointer width; at least one bit even for two requesters.
    function automatic int cr_ptr_w(input int n_reqs);
        return (n_reqs > 2) ? cr_clog2(n_reqs) : 1;
    endfunction

    // Slot ownership tag at its widest; instances use the low pReqs owner bits.
    typedef struct packed {
        logic                   valid;
        logic [CR_MAX_REQS-1:0] owner;
    } cr_tag_t;

endpackage

// File: rtl/cr_pipe_reg.sv
// Fixed-latency register pipeline of pStages stages; pStages=0 is a wire.
// Latency: exactly pStages cycles, advances every cycle.
// Backpressure: none; there is no stall input.
module cr_pipe_reg #(
    parameter int                pWidth          = 8,
    parameter int                pStages         = 1,
    parameter int                pRstMode        = 0,
    parameter logic [pWidth-1:0] StaticResetData = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [pWidth-1:0] d_i,
    output logic [pWidth-1:0] q_o
);

    if (pStages == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_n_i;
        assign q_o = d_i;
    end else begin : g_stages
        logic [pStages-1:0][pWidth-1:0] stg_q;

        if (pRstMode == 0) begin : g_async_rst
            // Shift register cleared to the static reset value by the async reset.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    for (int i = 0; i < pStages; i++) stg_q[i] <= StaticResetData;
                end else begin
                    stg_q[0] <= d_i;
                    for (int i = 1; i < pStages; i++) stg_q[i] <= stg_q[i-1];
                end
            end
        end else begin : g_no_rst
            logic unused_rst;
            assign unused_rst = rst_n_i;
            // Shift register without reset on the data path.
            always_ff @(posedge clk_i) begin
                stg_q[0] <= d_i;
                for (int i = 1; i < pStages; i++) stg_q[i] <= stg_q[i-1];
            end
        end

        assign q_o = stg_q[pStages-1];
    end

endmodule

// File: rtl/cr_rr_arb.sv
// One-hot round-robin grant with a wrapping priority pointer (optional lock: CR_PIPE_ARB_LOCK_EN).
// Latency: grant is combinational; pointer updates on the next edge.
// Backpressure: en_i low suppresses all grants; pointer holds.
module cr_rr_arb
    import cr_pipe_pkg::*;
#(
    parameter int pReqs = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [pReqs-1:0] req_i,
`ifdef CR_PIPE_ARB_LOCK_EN
    input  logic [pReqs-1:0] lock_i,
`endif
    output logic [pReqs-1:0] gnt_o
);

    localparam int PTR_W = cr_ptr_w(pReqs);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win;
    logic             hit;
    int               idx;

    // Search upward from the pointer, wrapping at pReqs, for the first valid request.
    always_comb begin
        gnt_o = '0;
        hit   = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < pReqs; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= pReqs) idx = idx - pReqs;
            if (!hit && en_i && req_i[idx]) begin
                hit = 1'b1;
                win = PTR_W'(idx);
            end
        end
        if (hit) gnt_o[win] = 1'b1;
    end

    // Next pointer: one past the winner (never reaching pReqs), or the winner itself while locked.
    always_comb begin
        ptr_d = ptr_q;
        if (hit) begin
            if (win == PTR_W'(pReqs - 1)) ptr_d = '0;
            else                          ptr_d = win + 1'b1;
`ifdef CR_PIPE_ARB_LOCK_EN
            if (lock_i[win]) ptr_d = win;
`endif
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cr_pipe_arb.sv
// Shares one fixed-latency pipeline among pReqs requesters and steers results back to their owner (optional lock: CR_PIPE_ARB_LOCK_EN).
// Latency: issue combinational; response exactly pStages cycles after issue.
// Backpressure: none on responses; en_i low blocks new grants while in-flight slots drain.
module cr_pipe_arb
    import cr_pipe_pkg::*;
#(
    parameter int pWidth  = 10,
    parameter int pReqs   = 4,
    parameter int pStages = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [pReqs-1:0]        req_valid_i,
    input  logic [pReqs*pWidth-1:0] req_data_i,
`ifdef CR_PIPE_ARB_LOCK_EN
    input  logic [pReqs-1:0]        req_lock_i,
`endif
    output logic [pReqs-1:0]        req_ready_o,
    output logic                    pipe_valid_o,
    output logic [pWidth-1:0]       pipe_d_o,
    input  logic [pWidth-1:0]       pipe_q_i,
    output logic [pReqs-1:0]        rsp_valid_o,
    output logic [pWidth-1:0]       rsp_data_o
);

    typedef struct packed {
        logic             valid;
        logic [pReqs-1:0] owner;
    } tag_t;

    tag_t tag_in, tag_out;

    cr_rr_arb #(
        .pReqs (pReqs)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .req_i   (req_valid_i),
`ifdef CR_PIPE_ARB_LOCK_EN
        .lock_i  (req_lock_i),
`endif
        .gnt_o   (req_ready_o)
    );

    // Issue mux: forward the granted requester's data, zero when idle.
    always_comb begin
        pipe_d_o = '0;
        for (int i = 0; i < pReqs; i++) begin
            if (req_ready_o[i]) pipe_d_o = req_data_i[i*pWidth +: pWidth];
        end
    end

    assign pipe_valid_o = |req_ready_o;

    // Owner tags travel alongside the data and are cleared with the pipeline.
    assign tag_in.valid = pipe_valid_o;
    assign tag_in.owner = req_ready_o;

    cr_pipe_reg #(
        .pWidth          (pReqs + 1),
        .pStages         (pStages),
        .pRstMode        (0),
        .StaticResetData ('0)
    ) u_tag_pipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (tag_in),
        .q_o     (tag_out)
    );

    assign rsp_valid_o = tag_out.valid ? tag_out.owner : '0;
    assign rsp_data_o  = pipe_q_i;

endmodule

// File: tb/tb_cr_pipe_arb.sv
// Self-checking bench for cr_pipe_arb (pReqs=4, pStages=5); lock cases built with CR_PIPE_ARB_LOCK_EN.
// Latency: response expected pStages cycles after each issue.
// Backpressure: responses must be taken the cycle they appear.
module tb_cr_pipe_arb;

    localparam int W = 10;
    localparam int N = 4;
    localparam int S = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             pipe_valid;
    logic [W-1:0]     pipe_d;
    logic [W-1:0]     pipe_q;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_data;
`ifdef CR_PIPE_ARB_LOCK_EN
    logic [N-1:0]     req_lock;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic         vld;
        logic [N-1:0] own;
        logic [W-1:0] dat;
    } exp_t;

    exp_t sbq[$];
    int   ptr_m;

    always #5 clk = ~clk;

    cr_pipe_arb #(
        .pWidth  (W),
        .pReqs   (N),
        .pStages (S)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .en_i         (en),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
`ifdef CR_PIPE_ARB_LOCK_EN
        .req_lock_i   (req_lock),
`endif
        .req_ready_o  (req_ready),
        .pipe_valid_o (pipe_valid),
        .pipe_d_o     (pipe_d),
        .pipe_q_i     (pipe_q),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data)
    );

    // Attached datapath: plain S-stage delay line sharing the arbiter reset.
    logic [S-1:0][W-1:0] pl;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl <= '0;
        end else begin
            pl[0] <= pipe_d;
            for (int i = 1; i < S; i++) pl[i] <= pl[i-1];
        end
    end
    assign pipe_q = pl[S-1];

    // Scoreboard: reference grant model, push expected slot, pop the one due now.
    initial begin : monitor
        exp_t         e;
        exp_t         p;
        logic [N-1:0] g;
        logic [N-1:0] rv_exp;
        logic [W-1:0] gd;
        int           gi;
        int           idx;
        forever begin
            @(negedge clk);
            g  = '0;
            gd = '0;
            gi = 0;
            for (int k = 0; k < N; k++) begin
                idx = (ptr_m + k) % N;
                if (g == '0 && en && req_valid[idx]) begin
                    g[idx] = 1'b1;
                    gi     = idx;
                    gd     = req_data[idx*W +: W];
                end
            end
            n_cmp++;
            if (req_ready !== g) begin
                n_fail++;
                $display("FAIL sb_grant t=%0t got %b expected %b", $time, req_ready, g);
            end
            n_cmp++;
            if (pipe_valid !== (|g)) begin
                n_fail++;
                $display("FAIL sb_pipe_valid t=%0t got %b expected %b", $time, pipe_valid, |g);
            end
            n_cmp++;
            if (pipe_d !== gd) begin
                n_fail++;
                $display("FAIL sb_pipe_d t=%0t got %h expected %h", $time, pipe_d, gd);
            end
            if (!rst_n) begin
                sbq.delete();
                for (int k = 0; k < S; k++) sbq.push_back('0);
                ptr_m = 0;
                n_cmp++;
                if (rsp_valid !== '0) begin
                    n_fail++;
                    $display("FAIL sb_rsp_in_reset t=%0t got %b expected 0", $time, rsp_valid);
                end
            end else begin
                e.vld = |g;
                e.own = g;
                e.dat = gd;
                sbq.push_back(e);
                p = sbq.pop_front();
                rv_exp = p.vld ? p.own : '0;
                n_cmp++;
                if (rsp_valid !== rv_exp) begin
                    n_fail++;
                    $display("FAIL sb_rsp_valid t=%0t got %b expected %b", $time, rsp_valid, rv_exp);
                end
                if (p.vld) begin
                    n_cmp++;
                    if (rsp_data !== p.dat) begin
                        n_fail++;
                        $display("FAIL sb_rsp_data t=%0t got %h expected %h", $time, rsp_data, p.dat);
                    end
                end
                if (|g) begin
                    ptr_m = (gi + 1) % N;
`ifdef CR_PIPE_ARB_LOCK_EN
                    if (req_lock[gi]) ptr_m = gi;
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom_range(0, 1023));
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
`ifdef CR_PIPE_ARB_LOCK_EN
        req_lock  = '0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== '0 || pipe_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold rsp_valid=%b pipe_valid=%b expected 0/0", rsp_valid, pipe_valid);
            end
            tick();
        end
        rst_n = 1'b1;
        repeat (S + 1) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== '0 || pipe_valid !== 1'b0 || pipe_d !== '0) begin
                n_fail++;
                $display("FAIL reset_idle rsp_valid=%b pipe_valid=%b pipe_d=%h expected 0", rsp_valid, pipe_valid, pipe_d);
            end
            tick();
        end
        req_valid = 4'b1111;
        rand_data();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ptr got %b expected 0001", req_ready);
        end
        tick();
        idle(S + 1);
    endtask

    task automatic test_all_valid();
        logic [N-1:0] exp_g;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 13; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            rand_data();
            @(negedge clk);
            if (k < 8) begin
                exp_g = 4'b0001 << (k % N);
                n_cmp++;
                if (req_ready !== exp_g) begin
                    n_fail++;
                    $display("FAIL all_valid_grant k=%0d got %b expected %b", k, req_ready, exp_g);
                end
            end
            if (k >= S) begin
                exp_g = 4'b0001 << ((k - S) % N);
                n_cmp++;
                if (rsp_valid !== exp_g || rsp_data !== pipe_q) begin
                    n_fail++;
                    $display("FAIL all_valid_rsp k=%0d got %b/%h expected %b/%h", k, rsp_valid, rsp_data, exp_g, pipe_q);
                end
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic [N-1:0] exp_r;
        idle(S + 1);
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 3) ? 4'b0100 : 4'b0000;
            rand_data();
            req_data[2*W +: W] = 10'h155;
            @(negedge clk);
            if (k < 3) begin
                n_cmp++;
                if (req_ready !== 4'b0100 || pipe_d !== 10'h155) begin
                    n_fail++;
                    $display("FAIL single_grant k=%0d got %b/%h expected 0100/155", k, req_ready, pipe_d);
                end
            end
            exp_r = (k >= S && k < S + 3) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (rsp_valid !== exp_r) begin
                n_fail++;
                $display("FAIL single_rsp k=%0d got %b expected %b", k, rsp_valid, exp_r);
            end
            tick();
        end
    endtask

    task automatic test_en_drop();
        logic [N-1:0] exp_g;
        logic [N-1:0] exp_r;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            en        = (k < 2);
            req_valid = (k < 6) ? 4'b1111 : 4'b0000;
            rand_data();
            @(negedge clk);
            exp_g = (k < 2) ? (4'b0001 << k) : 4'b0000;
            exp_r = (k == S) ? 4'b0001 : (k == S + 1) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (req_ready !== exp_g) begin
                n_fail++;
                $display("FAIL en_drop_grant k=%0d got %b expected %b", k, req_ready, exp_g);
            end
            n_cmp++;
            if (rsp_valid !== exp_r) begin
                n_fail++;
                $display("FAIL en_drop_rsp k=%0d got %b expected %b", k, rsp_valid, exp_r);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        en        = 1'b1;
        req_valid = 4'b1111;
        repeat (3) begin
            rand_data();
            tick();
        end
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < S + 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== '0) begin
                n_fail++;
                $display("FAIL midreset_rsp k=%0d got %b expected 0000", k, rsp_valid);
            end
            tick();
        end
        req_valid = 4'b1111;
        rand_data();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_ptr got %b expected 0001", req_ready);
        end
        tick();
        idle(S + 1);
    endtask

`ifdef CR_PIPE_ARB_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] exp_g;
        do_reset();
        en        = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            req_lock = (k < 5) ? 4'b0010 : 4'b0000;
            rand_data();
            @(negedge clk);
            exp_g = (k == 0) ? 4'b0001 : (k <= 5) ? 4'b0010 : (4'b0001 << ((k - 4) % N));
            n_cmp++;
            if (req_ready !== exp_g) begin
                n_fail++;
                $display("FAIL lock_grant k=%0d got %b expected %b", k, req_ready, exp_g);
            end
            tick();
        end
        req_lock = '0;
        idle(S + 1);
    endtask
`endif

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 80; k++) begin
            en        = ($urandom_range(0, 4) != 0);
            req_valid = N'($urandom_range(0, 15));
`ifdef CR_PIPE_ARB_LOCK_EN
            req_lock  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
`endif
            rand_data();
            tick();
        end
        en = 1'b0;
        idle(S + 2);
    endtask

    initial begin : main
        ptr_m     = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_data  = '0;
`ifdef CR_PIPE_ARB_LOCK_EN
        req_lock  = '0;
`endif
        test_reset();
        test_all_valid();
        test_single();
        test_en_drop();
        test_reset_midflight();
`ifdef CR_PIPE_ARB_LOCK_EN
        test_lock();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
